l2_fwd_stall_buf: RTL
=====================

# l2_fwd_stall_buf

Holding buffer for coherence forwards that the L2 request buffer has stalled during a forward peek, because they hit an in-flight request whose state cannot yet absorb them. Sits directly downstream of the L2 request buffer's forward-peek path: captures each stalled forward tagged with the blocking request slot index, and replays forwards to the L2 forward-handling pipeline in strict arrival order once their blocking slot is woken (state change or retire).

## Interface
Parameters:
- N_REQS, 4: request buffer slots.
- REQS_BITS, 2: slot index width, clog2(N_REQS).
- DEPTH, 4: stalled-forward capacity; power of two, ≥2.
- MSG_BITS, 5: coherence message width (mix_msg_t).
- LINE_ADDR_BITS, 26: line address width.
- ID_BITS, 4: requester/cache id width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- stall_valid  in  1  stalled forward offered (set_fwd_stall qualified).
- stall_ready  out  1  buffer can accept; equals !full.
- stall_reqs_i  in  REQS_BITS  blocking request slot.
- stall_msg  in  MSG_BITS  forward message type.
- stall_addr  in  LINE_ADDR_BITS  forward line address.
- stall_id  in  ID_BITS  forward requester id.
- wake_valid  in  1  blocking condition on slot wake_reqs_i cleared.
- wake_reqs_i  in  REQS_BITS  slot being woken.
- replay_valid  out  1  head entry released and presented.
- replay_ready  in  1  forward pipeline accepts head.
- replay_msg / replay_addr / replay_id / replay_reqs_i  out  as stall_*  head entry fields.
- count  out  clog2(DEPTH)+1  occupied entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

## Operation
- Circular FIFO: entries {valid, released, reqs_i, msg, addr, id}; head/tail pointers clog2(DEPTH) bits, wrap modulo DEPTH; separate count register.
- Enqueue: stall_valid && stall_ready writes at tail, valid=1, released=0, tail+1, count+1.
- Wake: wake_valid sets released=1 on every valid entry with reqs_i == wake_reqs_i. Entry being enqueued in the same cycle with matching index is written released=1.
- Wake on a slot with no matching entries: no effect, not remembered.
- Dequeue: only head may leave, and only when released. replay_valid = head valid && head released. replay_valid && replay_ready: clear head valid, head+1, count-1.
- Non-head entries never bypass an unreleased head; arrival order preserved even when later entries are released first.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. When full, stall_ready=0 even if dequeue occurs that cycle (no same-cycle bypass).
- replay_* fields hold head contents whenever replay_valid=1 and stay stable until accepted.
- Reset: all valid/released bits, pointers, count cleared. Outputs: stall_ready=1, replay_valid=0, replay fields 0, count=0, empty=1, full=0. Reset mid-operation discards all held forwards.

## Timing
- Enqueue in cycle t: entry visible from t+1. With matching same-cycle wake and an empty buffer, replay_valid=1 in t+1.
- Wake in cycle t: released bit set at end of t; replay_valid rises in t+1 if entry is head.
- Replay outputs are combinational from registered head state; no combinational path from stall_* or wake_* to replay_*.
- stall_ready depends only on registered count.
- Accept in t: next head presented in t+1 if already released. Sustained throughput 1 replay/cycle.

## Structure
- spandex_consts.svh: L2_FWD_STALL_DEPTH.
- spandex_types.svh: fwd_stall_entry_t {valid, released, reqs_i, msg, addr, id}.
- Single module. Entry array and per-entry wake-compare generated inline. No sub-module.

## Test plan
- Enqueue (slot 2, FWD_INV, addr 0x100), no wake for 10 cycles -> replay_valid stays 0, count=1. Wake slot 2 -> replay_valid=1 next cycle with addr 0x100. Accept -> empty=1.
- Enqueue A(slot 1) then B(slot 3). Wake slot 3 first, then slot 1 five cycles later -> A replays then B. B never precedes A.
- Fill 4 entries -> full=1, stall_ready=0. Offer a 5th with replay_ready=1 on a released head -> 5th rejected that cycle, accepted next cycle. Count sequence 4,3,4.
- Same-cycle enqueue on empty buffer (slot 0) with wake slot 0 -> replay_valid=1 at t+1.
- Three entries on slot 2; single wake -> all released, replayed back-to-back over 3 cycles with replay_ready held high.
- Assert rst with 3 entries held, replay_ready low -> replay_valid=0, count=0, empty=1 immediately. After release, enqueue works from pointer 0.

Source files
------------

// File: rtl/l2_fwd_stall_buf_pkg.sv
// Shared constants and entry layout for the L2 stalled-forward holding buffer.
package l2_fwd_stall_buf_pkg;

  localparam int L2_N_REQS           = 4;
  localparam int L2_REQS_BITS        = 2;
  localparam int L2_FWD_STALL_DEPTH  = 4;
  localparam int L2_MSG_BITS         = 5;
  localparam int L2_LINE_ADDR_BITS   = 26;
  localparam int L2_ID_BITS          = 4;

  // Forward message encodings used by the L2 forward path.
  localparam logic [L2_MSG_BITS-1:0] FWD_REQ_S = 5'd8;
  localparam logic [L2_MSG_BITS-1:0] FWD_REQ_O = 5'd9;
  localparam logic [L2_MSG_BITS-1:0] FWD_INV   = 5'd12;

  typedef struct packed {
    logic                         valid;
    logic                         released;
    logic [L2_REQS_BITS-1:0]      reqs_i;
    logic [L2_MSG_BITS-1:0]       msg;
    logic [L2_LINE_ADDR_BITS-1:0] addr;
    logic [L2_ID_BITS-1:0]        id;
  } fwd_stall_entry_t;

endpackage

// File: rtl/l2_fwd_stall_buf.sv
// Holds forwards stalled on an in-flight request slot and replays them in
// arrival order once the blocking slot is woken.
module l2_fwd_stall_buf
  import l2_fwd_stall_buf_pkg::*;
#(
  parameter int N_REQS         = L2_N_REQS,
  parameter int REQS_BITS      = L2_REQS_BITS,
  parameter int DEPTH          = L2_FWD_STALL_DEPTH,
  parameter int MSG_BITS       = L2_MSG_BITS,
  parameter int LINE_ADDR_BITS = L2_LINE_ADDR_BITS,
  parameter int ID_BITS        = L2_ID_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_valid,
  output logic                      stall_ready,
  input  logic [REQS_BITS-1:0]      stall_reqs_i,
  input  logic [MSG_BITS-1:0]       stall_msg,
  input  logic [LINE_ADDR_BITS-1:0] stall_addr,
  input  logic [ID_BITS-1:0]        stall_id,
  input  logic                      wake_valid,
  input  logic [REQS_BITS-1:0]      wake_reqs_i,
  output logic                      replay_valid,
  input  logic                      replay_ready,
  output logic [MSG_BITS-1:0]       replay_msg,
  output logic [LINE_ADDR_BITS-1:0] replay_addr,
  output logic [ID_BITS-1:0]        replay_id,
  output logic [REQS_BITS-1:0]      replay_reqs_i,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  output logic                      full
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;

  typedef struct packed {
    logic                      valid;
    logic                      released;
    logic [REQS_BITS-1:0]      reqs_i;
    logic [MSG_BITS-1:0]       msg;
    logic [LINE_ADDR_BITS-1:0] addr;
    logic [ID_BITS-1:0]        id;
  } entry_t;

  // Handshakes: a transfer happens on a cycle where valid && ready are both
  // high at the rising edge; valid never waits on ready, and stall_ready is
  // derived from registered occupancy only.
  entry_t              mem [DEPTH];
  logic [PTR_BITS-1:0] head;
  logic [PTR_BITS-1:0] tail;
  logic [CNT_BITS-1:0] count_q;
  logic                enq;
  logic                deq;
  entry_t              head_entry;

  assign head_entry   = mem[head];
  assign full         = (count_q == CNT_BITS'(DEPTH));
  assign empty        = (count_q == '0);
  assign count        = count_q;
  assign stall_ready  = !full;
  assign replay_valid = head_entry.valid && head_entry.released;
  assign replay_msg    = head_entry.msg;
  assign replay_addr   = head_entry.addr;
  assign replay_id     = head_entry.id;
  assign replay_reqs_i = head_entry.reqs_i;

  assign enq = stall_valid && stall_ready;
  assign deq = replay_valid && replay_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wake_valid && mem[i].valid && (mem[i].reqs_i == wake_reqs_i))
          mem[i].released <= 1'b1;
      end
      // Enqueue never targets the head slot while it is being dequeued:
      // that would require full, which blocks enqueue.
      if (deq) begin
        mem[head].valid    <= 1'b0;
        mem[head].released <= 1'b0;
        head               <= head + PTR_BITS'(1);
      end
      if (enq) begin
        mem[tail] <= '{valid:    1'b1,
                       released: wake_valid && (wake_reqs_i == stall_reqs_i),
                       reqs_i:   stall_reqs_i,
                       msg:      stall_msg,
                       addr:     stall_addr,
                       id:       stall_id};
        tail <= tail + PTR_BITS'(1);
      end
      case ({enq, deq})
        2'b10:   count_q <= count_q + CNT_BITS'(1);
        2'b01:   count_q <= count_q - CNT_BITS'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
